usb_rx_top_level: RTL and testbench

USB_RX_TOP_LEVEL -- requirements
Module: usb_rx_top_level

---
 rtl/usb_rx_top_level.sv | 206 ++++++++++++++++++++
 tb/tb_usb_rx_top_level.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_rx_top_level.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | usb_rx_top_level: USB receiver (sync, NRZI decode, unstuff, bytes) |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module usb_rx_top_level (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       d_plus_in,
  input  logic       d_minus_in,
  input  logic       packet_type,
  output logic [7:0] rx_data,
  output logic       write_enable,
  output logic       rcv_error
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SYNC  = 3'd1,
    RCV   = 3'd2,
    WRITE = 3'd3,
    EOP   = 3'd4,
    EIDLE = 3'd5
  } state_t;

  localparam logic [7:0] C_SYNC_PATTERN = 8'h54;
  localparam logic [2:0] C_SAMPLE_POINT = 3'd3;

  state_t     state_q, state_d;
  logic       dp_meta_q, dp_meta_d, dp_sync_q, dp_sync_d, dp_prev_q, dp_prev_d;
  logic       dm_meta_q, dm_meta_d, dm_sync_q, dm_sync_d;
  logic [2:0] timer_q, timer_d;
  logic       ref_q, ref_d;
  logic [2:0] ones_q, ones_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [2:0] byte_cnt_q, byte_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rcv_error_q, rcv_error_d;
  logic       eop_seen_q, eop_seen_d;
  logic       ptype_q, ptype_d;

  logic       sample, se0, bus_j, sop, dec_bit, stuffed, stuff_err;
  logic [7:0] shift_next;

  always_comb begin
    dp_meta_d = d_plus_in;
    dp_sync_d = dp_meta_q;
    dp_prev_d = dp_sync_q;
    dm_meta_d = d_minus_in;
    dm_sync_d = dm_meta_q;
    // Every D+ transition realigns the bit clock to the transmitter.
    timer_d   = (dp_sync_q != dp_prev_q) ? 3'd0 : timer_q + 3'd1;
  end

  assign sample     = (timer_q == C_SAMPLE_POINT);
  assign se0        = ~dp_sync_q & ~dm_sync_q;
  assign bus_j      = dp_sync_q & ~dm_sync_q;
  assign sop        = dp_prev_q & ~dp_sync_q;
  assign dec_bit    = (dp_sync_q == ref_q);
  assign stuffed    = (ones_q == 3'd6) & ~dec_bit;
  assign stuff_err  = (ones_q == 3'd6) & dec_bit;
  assign shift_next = {shift_q[6:0], dec_bit};

  always_comb begin
    state_d     = state_q;
    ref_d       = ref_q;
    ones_d      = ones_q;
    bit_cnt_d   = bit_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rcv_error_d = rcv_error_q;
    eop_seen_d  = eop_seen_q;
    ptype_d     = ptype_q;
    case (state_q)
      IDLE: begin
        if (sop) begin
          state_d     = SYNC;
          rcv_error_d = 1'b0;
          ref_d       = 1'b1;
          ones_d      = 3'd0;
          bit_cnt_d   = 3'd0;
          byte_cnt_d  = 3'd0;
          shift_d     = 8'h00;
          eop_seen_d  = 1'b0;
        end
      end
      SYNC: begin
        if (sample) begin
          if (se0) begin
            state_d     = EIDLE;
            rcv_error_d = 1'b1;
            eop_seen_d  = 1'b1;
          end else begin
            ref_d     = dp_sync_q;
            ones_d    = dec_bit ? ones_q + 3'd1 : 3'd0;
            shift_d   = shift_next;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (shift_next == C_SYNC_PATTERN) begin
                state_d = RCV;
                ptype_d = packet_type;
              end else begin
                state_d     = EIDLE;
                rcv_error_d = 1'b1;
              end
            end
          end
        end
      end
      RCV: begin
        if (sample) begin
          // SE0 wins over a data bit, so a byte ending on it stays partial.
          if (se0) begin
            eop_seen_d = 1'b1;
            if ((bit_cnt_q != 3'd0) || (ptype_q && (byte_cnt_q != 3'd3))) begin
              state_d     = EIDLE;
              rcv_error_d = 1'b1;
            end else begin
              state_d = EOP;
            end
          end else begin
            ref_d = dp_sync_q;
            if (stuff_err) begin
              state_d     = EIDLE;
              rcv_error_d = 1'b1;
            end else if (stuffed) begin
              ones_d = 3'd0;
            end else begin
              ones_d    = dec_bit ? ones_q + 3'd1 : 3'd0;
              shift_d   = shift_next;
              bit_cnt_d = bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                state_d   = WRITE;
                rx_data_d = shift_next;
                if (byte_cnt_q != 3'd7) begin
                  byte_cnt_d = byte_cnt_q + 3'd1;
                end
              end
            end
          end
        end
      end
      WRITE: state_d = RCV;
      EOP: begin
        if (bus_j) begin
          state_d = IDLE;
        end
      end
      EIDLE: begin
        if (sample && se0) begin
          eop_seen_d = 1'b1;
        end
        if (eop_seen_q && bus_j) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      state_q     <= IDLE;
      dp_meta_q   <= 1'b1;
      dp_sync_q   <= 1'b1;
      dp_prev_q   <= 1'b1;
      dm_meta_q   <= 1'b0;
      dm_sync_q   <= 1'b0;
      timer_q     <= 3'd0;
      ref_q       <= 1'b1;
      ones_q      <= 3'd0;
      bit_cnt_q   <= 3'd0;
      byte_cnt_q  <= 3'd0;
      shift_q     <= 8'h00;
      rx_data_q   <= 8'h00;
      rcv_error_q <= 1'b0;
      eop_seen_q  <= 1'b0;
      ptype_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      dp_meta_q   <= dp_meta_d;
      dp_sync_q   <= dp_sync_d;
      dp_prev_q   <= dp_prev_d;
      dm_meta_q   <= dm_meta_d;
      dm_sync_q   <= dm_sync_d;
      timer_q     <= timer_d;
      ref_q       <= ref_d;
      ones_q      <= ones_d;
      bit_cnt_q   <= bit_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rcv_error_q <= rcv_error_d;
      eop_seen_q  <= eop_seen_d;
      ptype_q     <= ptype_d;
    end
  end

  assign rx_data      = rx_data_q;
  assign write_enable = (state_q == WRITE);
  assign rcv_error    = rcv_error_q;

endmodule
`default_nettype wire

// File: tb/tb_usb_rx_top_level.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_usb_rx_top_level: randomized bench for usb_rx_top_level          |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module tb_usb_rx_top_level;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       d_plus_in;
  logic       d_minus_in;
  logic       packet_type;
  logic [7:0] rx_data;
  logic       write_enable;
  logic       rcv_error;

  usb_rx_top_level dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .d_plus_in    (d_plus_in),
    .d_minus_in   (d_minus_in),
    .packet_type  (packet_type),
    .rx_data      (rx_data),
    .write_enable (write_enable),
    .rcv_error    (rcv_error)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_pass   = 0;
  bit         tx_bits[$];
  logic [7:0] data_q[$];
  logic [7:0] exp_bytes[$];
  logic [7:0] got_bytes[$];
  bit         exp_err;
  logic [7:0] last_byte = 8'h00;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  always @(negedge clk) begin
    if (write_enable === 1'b1) got_bytes.push_back(rx_data);
  end

  task automatic hold_bus(input logic dp, input logic dm, input int n);
    d_plus_in  = dp;
    d_minus_in = dm;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_raw(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) tx_bits.push_back(b[i]);
  endtask

  // Transmitter view: sync then data with a 0 inserted after six 1s.
  task automatic build_valid();
    int ones;
    ones = 0;
    tx_bits.delete();
    push_raw(8'h54);
    foreach (data_q[k]) begin
      for (int i = 7; i >= 0; i--) begin
        tx_bits.push_back(data_q[k][i]);
        ones = data_q[k][i] ? ones + 1 : 0;
        if (ones == 6) begin
          tx_bits.push_back(1'b0);
          ones = 0;
        end
      end
    end
  endtask

  // Receiver rules applied to the whole decoded bit list at once.
  task automatic model(input bit pt);
    int         ones;
    int         cnt;
    logic [7:0] cur;
    logic [7:0] sync_v;
    ones = 0; cnt = 0; cur = 8'h00; sync_v = 8'h00;
    exp_bytes.delete();
    exp_err = 1'b0;
    if (tx_bits.size() < 8) begin
      exp_err = 1'b1;
      return;
    end
    for (int i = 0; i < 8; i++) sync_v = {sync_v[6:0], tx_bits[i]};
    if (sync_v != 8'h54) begin
      exp_err = 1'b1;
      return;
    end
    for (int i = 8; i < tx_bits.size(); i++) begin
      if (ones == 6) begin
        if (tx_bits[i]) begin
          exp_err = 1'b1;
          return;
        end
        ones = 0;
        continue;
      end
      ones = tx_bits[i] ? ones + 1 : 0;
      cur  = {cur[6:0], tx_bits[i]};
      cnt++;
      if (cnt == 8) begin
        exp_bytes.push_back(cur);
        cnt = 0;
      end
    end
    if ((cnt != 0) || (pt && (exp_bytes.size() != 3))) exp_err = 1'b1;
  endtask

  // NRZI-encode tx_bits onto the bus; limit >= 0 stops early with no EOP.
  task automatic send_packet(input bit pt, input int limit);
    logic lvl;
    lvl = 1'b1;
    packet_type = pt;
    for (int i = 0; i < tx_bits.size(); i++) begin
      if ((limit >= 0) && (i == limit)) return;
      if (!tx_bits[i]) lvl = ~lvl;
      hold_bus(lvl, ~lvl, 8);
      if (i == 0) check("err_clear_at_sop", 32'(rcv_error), 32'd0);
    end
    hold_bus(1'b0, 1'b0, 16);
    hold_bus(1'b1, 1'b0, 24);
  endtask

  task automatic run_and_check(input string tag, input bit pt);
    model(pt);
    got_bytes.delete();
    hold_bus(1'b1, 1'b0, 16);
    send_packet(pt, -1);
    check({tag, "_nbytes"}, 32'(got_bytes.size()), 32'(exp_bytes.size()));
    foreach (exp_bytes[k]) begin
      if (k < got_bytes.size()) check({tag, "_byte"}, 32'(got_bytes[k]), 32'(exp_bytes[k]));
    end
    check({tag, "_err"}, 32'(rcv_error), 32'(exp_err));
    if (exp_bytes.size() > 0) last_byte = exp_bytes[exp_bytes.size() - 1];
    check({tag, "_rx_hold"}, 32'(rx_data), 32'(last_byte));
  endtask

  initial begin
    int  kind;
    int  n;
    int  idx;
    bit  pt;
    logic [7:0] b;

    n_rst       = 1'b1;
    packet_type = 1'b0;
    hold_bus(1'b1, 1'b0, 4);
    check("reset_rx_data", 32'(rx_data), 32'd0);
    check("reset_we", 32'(write_enable), 32'd0);
    check("reset_err", 32'(rcv_error), 32'd0);
    n_rst = 1'b0;
    hold_bus(1'b1, 1'b0, 8);

    data_q = '{8'hA5};
    build_valid();
    run_and_check("single_a5", 1'b0);

    tx_bits.delete();
    push_raw(8'h54); push_raw(8'hF0); push_raw(8'hFD);
    run_and_check("stuff_partial", 1'b0);

    tx_bits.delete();
    push_raw(8'h56); push_raw(8'h3C);
    run_and_check("bad_sync", 1'b0);

    data_q = '{8'h12, 8'hFF};
    build_valid();
    run_and_check("after_bad_sync", 1'b0);

    data_q = '{8'h2D, 8'h00, 8'h10};
    build_valid();
    run_and_check("token3", 1'b1);

    data_q = '{8'h2D, 8'h00};
    build_valid();
    run_and_check("token2", 1'b1);

    tx_bits.delete();
    push_raw(8'h54); push_raw(8'hFF); push_raw(8'h81);
    run_and_check("seven_ones", 1'b0);

    data_q = '{8'h7E, 8'h81};
    build_valid();
    run_and_check("after_seven_ones", 1'b0);

    for (int p = 0; p < 16; p++) begin
      kind = $urandom_range(0, 3);
      pt   = (kind == 1);
      n    = pt ? (($urandom_range(0, 2) == 0) ? $urandom_range(0, 5) : 3) : $urandom_range(0, 4);
      data_q.delete();
      for (int j = 0; j < n; j++) begin
        case ($urandom_range(0, 3))
          0:       b = 8'hFF;
          1:       b = 8'h7E;
          default: b = 8'($urandom);
        endcase
        data_q.push_back(b);
      end
      build_valid();
      if (kind == 2) begin
        idx = $urandom_range(0, tx_bits.size() - 1);
        tx_bits[idx] = ~tx_bits[idx];
      end
      if ((kind == 3) && (data_q.size() > 0)) begin
        repeat ($urandom_range(1, 7)) void'(tx_bits.pop_back());
      end
      run_and_check("rand", pt);
    end

    // Reset while inside the error-idle part of a packet that already wrote a byte.
    tx_bits.delete();
    push_raw(8'h54); push_raw(8'h3C); push_raw(8'hFE); push_raw(8'h55);
    got_bytes.delete();
    hold_bus(1'b1, 1'b0, 16);
    send_packet(1'b0, 28);
    check("pre_rst_nbytes", 32'(got_bytes.size()), 32'd1);
    check("pre_rst_err", 32'(rcv_error), 32'd1);
    n_rst = 1'b1;
    #1;
    check("rst_rx_data", 32'(rx_data), 32'd0);
    check("rst_we", 32'(write_enable), 32'd0);
    check("rst_err", 32'(rcv_error), 32'd0);
    hold_bus(1'b1, 1'b0, 5);
    n_rst = 1'b0;
    hold_bus(1'b1, 1'b0, 24);
    check("post_rst_nbytes", 32'(got_bytes.size()), 32'd1);
    last_byte = 8'h00;

    data_q = '{8'hC3, 8'h5A};
    build_valid();
    run_and_check("after_reset", 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
